// File: rtl/pwm_duty_modulator.sv
// PWM stage: converts a 0..STEPS level into a duty-cycle waveform with a run-time prescaler.
// Optional complementary output with dead-time when PWM_DEADTIME_EN is defined.
module pwm_duty_modulator #(
  parameter int PRESC_W = 8,
  parameter int STEPS   = 10
`ifdef PWM_DEADTIME_EN
  ,
  parameter int DEAD    = 2
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [3:0]         level,
  input  logic [PRESC_W-1:0] presc,
  output logic               pwm_out,
  output logic               period_start,
  output logic [3:0]         duty_q
`ifdef PWM_DEADTIME_EN
  ,
  output logic               pwm_n
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  localparam logic [3:0] STEPS_L = 4'(STEPS);
  localparam logic [3:0] LAST_L  = 4'(STEPS - 1);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [3:0]         step_cnt_q, step_cnt_d;
  logic [3:0]         duty_d;
  logic [3:0]         level_clamped;
  logic               pwm_d;
  logic               period_start_d;
  logic               tick;
  logic               boundary;

  assign level_clamped = (level > STEPS_L) ? STEPS_L : level;
  // >= rather than == so that lowering presc below the running count ticks at once.
  assign tick          = (pre_cnt_q >= presc);
  assign boundary      = tick && (step_cnt_q == LAST_L);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d        = state_q;
    pre_cnt_d      = pre_cnt_q;
    step_cnt_d     = step_cnt_q;
    duty_d         = duty_q;
    period_start_d = 1'b0;

    case (state_q)
      IDLE: begin
        pre_cnt_d  = '0;
        step_cnt_d = '0;
        if (en) begin
          state_d        = RUN;
          duty_d         = level_clamped;
          period_start_d = 1'b1;
        end
      end
      default: begin
        if (tick) begin
          pre_cnt_d  = '0;
          step_cnt_d = boundary ? 4'd0 : step_cnt_q + 4'd1;
        end else begin
          pre_cnt_d = pre_cnt_q + 1'b1;
        end

        // The boundary is resolved against the state held before this cycle's en change.
        if (boundary) begin
          if ((state_q == RUN) || en) begin
            duty_d         = level_clamped;
            period_start_d = 1'b1;
            state_d        = en ? RUN : DRAIN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = en ? RUN : DRAIN;
        end
      end
    endcase

    pwm_d = (state_d != IDLE) && (step_cnt_d < duty_d);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q      <= IDLE;
      pre_cnt_q    <= '0;
      step_cnt_q   <= '0;
      duty_q       <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      step_cnt_q   <= step_cnt_d;
      duty_q       <= duty_d;
      pwm_out      <= pwm_d;
      period_start <= period_start_d;
    end
  end

`ifdef PWM_DEADTIME_EN
  localparam int DW = (DEAD > 0) ? $clog2(DEAD + 1) : 1;

  logic [DW-1:0] dead_q, dead_d;
  logic          pwm_n_d;

  // Every pwm_out edge reloads the guard; pwm_n may only drive once it has run out.
  always_comb begin
    dead_d = dead_q;
    if (pwm_d != pwm_out) begin
      dead_d = DW'(DEAD);
    end else if (dead_q != '0) begin
      dead_d = dead_q - 1'b1;
    end
    pwm_n_d = (state_d != IDLE) && !pwm_d && (dead_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dead_q <= '0;
      pwm_n  <= 1'b0;
    end else begin
      dead_q <= dead_d;
      pwm_n  <= pwm_n_d;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_duty_modulator.sv
// Directed bench for pwm_duty_modulator: reset, duty patterns, deferred reload,
// clamp, drain, prescaler lowering and (when PWM_DEADTIME_EN is defined) dead-time.
module tb_pwm_duty_modulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] level;
  logic [7:0] presc;
  logic       pwm_out;
  logic       period_start;
  logic [3:0] duty_q;
`ifdef PWM_DEADTIME_EN
  logic       pwm_n;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [39:0] pv, pe, sv, se;

  pwm_duty_modulator dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .level        (level),
    .presc        (presc),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .duty_q       (duty_q)
`ifdef PWM_DEADTIME_EN
    ,
    .pwm_n        (pwm_n)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    en    = 1'b0;
    level = 4'd0;
    presc = 8'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic clear_vecs();
    pv = '0; pe = '0; sv = '0; se = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (pwm_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_pwm: got %b expected 0", pwm_out);
    end
    n_checks++;
    if (duty_q !== 4'd0) begin
      n_fail++; $display("FAIL reset_duty: got %0d expected 0", duty_q);
    end
    n_checks++;
    if (period_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_ps: got %b expected 0", period_start);
    end
    clear_vecs();
    level = 4'd5;
    for (int i = 0; i < 5; i++) begin
      step();
      pv[i] = pwm_out;
      sv[i] = period_start;
    end
    n_checks++;
    if ((pv | sv) !== 40'd0) begin
      n_fail++; $display("FAIL idle_hold: got pwm=%h ps=%h expected all zero", pv, sv);
    end
  endtask

  task automatic test_basic_duty();
    do_reset();
    clear_vecs();
    presc = 8'd0; level = 4'd3; en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      pv[i] = pwm_out;
      sv[i] = period_start;
      pe[i] = ((i % 10) < 3);
      se[i] = ((i % 10) == 0);
    end
    n_checks++;
    if (pv !== pe) begin
      n_fail++; $display("FAIL basic_pwm: got %h expected %h", pv, pe);
    end
    n_checks++;
    if (sv !== se) begin
      n_fail++; $display("FAIL basic_ps: got %h expected %h", sv, se);
    end
    n_checks++;
    if (duty_q !== 4'd3) begin
      n_fail++; $display("FAIL basic_duty: got %0d expected 3", duty_q);
    end
  endtask

  task automatic test_midrun_reset();
    do_reset();
    presc = 8'd0; level = 4'd5; en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (pwm_out !== 1'b1) begin
      n_fail++; $display("FAIL midrun_pre: got %b expected 1", pwm_out);
    end
    rst = 1'b1;
    step();
    n_checks++;
    if (pwm_out !== 1'b0 || duty_q !== 4'd0 || period_start !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_rst: got pwm=%b duty=%0d ps=%b expected 0 0 0", pwm_out, duty_q, period_start);
    end
    en  = 1'b0;
    rst = 1'b0;
    step();
    step();
    n_checks++;
    if (pwm_out !== 1'b0 || period_start !== 1'b0) begin
      n_fail++; $display("FAIL midrun_idle: got pwm=%b ps=%b expected 0 0", pwm_out, period_start);
    end
  endtask

  task automatic test_deferred_update();
    do_reset();
    clear_vecs();
    presc = 8'd1; level = 4'd2; en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      pv[i] = pwm_out;
      sv[i] = period_start;
      pe[i] = (i < 20) ? (i < 4) : ((i - 20) < 16);
      se[i] = (i == 0) || (i == 20);
      if (i == 5) level = 4'd8;
    end
    n_checks++;
    if (pv !== pe) begin
      n_fail++; $display("FAIL deferred_pwm: got %h expected %h", pv, pe);
    end
    n_checks++;
    if (sv !== se) begin
      n_fail++; $display("FAIL deferred_ps: got %h expected %h", sv, se);
    end
    n_checks++;
    if (duty_q !== 4'd8) begin
      n_fail++; $display("FAIL deferred_duty: got %0d expected 8", duty_q);
    end
  endtask

  task automatic test_extremes();
    do_reset();
    clear_vecs();
    presc = 8'd0; level = 4'd0; en = 1'b1;
    for (int i = 0; i < 35; i++) begin
      step();
      pv[i] = pwm_out;
      pe[i] = (i >= 10);
      if (i == 5) begin
        n_checks++;
        if (duty_q !== 4'd0) begin
          n_fail++; $display("FAIL zero_duty: got %0d expected 0", duty_q);
        end
      end
      if (i == 3)  level = 4'd10;
      if (i == 15) level = 4'd15;
    end
    n_checks++;
    if (pv !== pe) begin
      n_fail++; $display("FAIL extremes_pwm: got %h expected %h", pv, pe);
    end
    n_checks++;
    if (duty_q !== 4'd10) begin
      n_fail++; $display("FAIL clamp_reload: got %0d expected 10", duty_q);
    end
    do_reset();
    level = 4'd15; en = 1'b1;
    step();
    n_checks++;
    if (duty_q !== 4'd10 || pwm_out !== 1'b1) begin
      n_fail++; $display("FAIL clamp_entry: got duty=%0d pwm=%b expected 10 1", duty_q, pwm_out);
    end
  endtask

  task automatic test_drain();
    do_reset();
    clear_vecs();
    presc = 8'd0; level = 4'd6; en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      pv[i] = pwm_out;
      sv[i] = period_start;
      pe[i] = (i < 6);
      se[i] = (i == 0);
      if (i == 2) en = 1'b0;
    end
    n_checks++;
    if (pv !== pe) begin
      n_fail++; $display("FAIL drain_pwm: got %h expected %h", pv, pe);
    end
    n_checks++;
    if (sv !== se) begin
      n_fail++; $display("FAIL drain_ps: got %h expected %h", sv, se);
    end

    do_reset();
    clear_vecs();
    presc = 8'd0; level = 4'd6; en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      pv[i] = pwm_out;
      sv[i] = period_start;
      pe[i] = ((i % 10) < 6);
      se[i] = ((i % 10) == 0);
      if (i == 2) en = 1'b0;
      if (i == 8) en = 1'b1;
    end
    n_checks++;
    if (pv !== pe) begin
      n_fail++; $display("FAIL reraise_pwm: got %h expected %h", pv, pe);
    end
    n_checks++;
    if (sv !== se) begin
      n_fail++; $display("FAIL reraise_ps: got %h expected %h", sv, se);
    end
  endtask

  task automatic test_presc_lower();
    do_reset();
    clear_vecs();
    presc = 8'd3; level = 4'd1; en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      pv[i] = pwm_out;
      sv[i] = period_start;
      pe[i] = (i < 3) || (i == 12);
      se[i] = (i == 0) || (i == 12);
      if (i == 2) presc = 8'd0;
    end
    n_checks++;
    if (pv !== pe) begin
      n_fail++; $display("FAIL presc_lower_pwm: got %h expected %h", pv, pe);
    end
    n_checks++;
    if (sv !== se) begin
      n_fail++; $display("FAIL presc_lower_ps: got %h expected %h", sv, se);
    end
  endtask

`ifdef PWM_DEADTIME_EN
  task automatic test_deadtime();
    do_reset();
    clear_vecs();
    presc = 8'd0; level = 4'd5; en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      pv[i] = pwm_n;
      pe[i] = ((i % 10) >= 7);
    end
    n_checks++;
    if (pv !== pe) begin
      n_fail++; $display("FAIL deadtime_pwm_n: got %h expected %h", pv, pe);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; level = 4'd0; presc = 8'd0;
    test_reset();
    test_basic_duty();
    test_midrun_reset();
    test_deferred_update();
    test_extremes();
    test_drain();
    test_presc_lower();
`ifdef PWM_DEADTIME_EN
    test_deadtime();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
